// File: rtl/sha_pkg.sv
// Shared types for the bit-serial word source.
// Word width default, counter type and FSM states.
package sha_pkg;

  localparam int W_WORD = 32;

  typedef logic [$clog2(W_WORD)-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock generator: divides clk by 2*DIV while enabled.
// Emits single-cycle strobes for the edge where bclk rises or falls.
module bclk_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(DIV + 1);

  logic [DW-1:0] div_q;
  logic          bclk_q;
  logic          tick;

  assign tick = en && (div_q == DW'(DIV - 1));
  assign rise = tick && !bclk_q;
  assign fall = tick && bclk_q;
  assign bclk = bclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (!en) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      div_q  <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/bserial_src.sv
// Parallel-to-serial word source, LSB first, with a one-word holding
// register so consecutive words stream without a bclk gap.
module bserial_src
  import sha_pkg::*;
#(
  parameter int W   = 32,
  parameter int DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  output logic                 bclk,
  output logic [$clog2(W)-1:0] counter,
  output logic                 out,
  output logic                 word_start,
  output logic                 busy
);

  localparam int CW = $clog2(W);

  state_t         state_q, state_d;
  logic [W-1:0]   hold_q;
  logic           hold_full_q;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ws_q;
  logic           load;
  logic           accept;
  logic           last;
  logic           en;
  logic           rise;
  logic           fall;

  assign en     = (state_q == RUN);
  assign accept = in_valid && !hold_full_q;
  assign last   = (cnt_q == CW'(W - 1));

  bclk_gen #(
    .DIV (DIV)
  ) u_bclk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bclk  (bclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (fall) begin
          if (!last) begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = shift_q >> 1;
          end else if (hold_full_q) begin
            load    = 1'b1;
          end else begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A load always restarts at bit 0, from IDLE or mid-stream
    if (load) begin
      shift_d = hold_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ws_q    <= load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= in_data;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  a_rise_busy: assert property (
    @(posedge clk) disable iff (!rst_n) rise |-> en
  );

  assign in_ready   = !hold_full_q;
  assign out        = shift_q[0];
  assign counter    = cnt_q;
  assign word_start = ws_q;
  assign busy       = en;

endmodule

// File: tb/tb_bserial_src.sv
// Bench for bserial_src: DIV=1 and DIV=3 instances checked each cycle
// against a word/position reference model plus a bit scoreboard.
module tb_bserial_src;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  int            sel = 0;

  logic          v1, r1, b1, o1, ws1, bz1;
  logic          v3, r3, b3, o3, ws3, bz3;
  logic [4:0]    c1, c3;
  logic [9:0]    obs;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  int            div_m;
  logic          m_busy, m_hold, m_acc;
  int            m_k;
  logic [W-1:0]  m_cur, m_holdw;

  always #5 clk = ~clk;

  assign v1 = in_valid && (sel == 0);
  assign v3 = in_valid && (sel == 1);
  assign obs = (sel == 1) ? {r3, bz3, b3, o3, ws3, c3}
                          : {r1, bz1, b1, o1, ws1, c1};

  bserial_src #(.W(W), .DIV(1)) u_d1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v1),
    .in_data    (in_data),
    .in_ready   (r1),
    .bclk       (b1),
    .counter    (c1),
    .out        (o1),
    .word_start (ws1),
    .busy       (bz1)
  );

  bserial_src #(.W(W), .DIV(3)) u_d3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (v3),
    .in_data    (in_data),
    .in_ready   (r3),
    .bclk       (b3),
    .counter    (c3),
    .out        (o3),
    .word_start (ws3),
    .busy       (bz3)
  );

  // Expected {ready,busy,bclk,out,word_start,counter} from word position
  function automatic logic [9:0] expv();
    logic [9:0] e;
    int b;
    e = '0;
    e[9] = !m_hold;
    if (m_busy) begin
      b = m_k / (2 * div_m);
      e[8] = 1'b1;
      e[7] = ((m_k / div_m) % 2) == 1;
      e[6] = m_cur[b];
      e[5] = (m_k == 0);
      e[4:0] = 5'(b);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_acc = 0;
    m_k = 0; m_cur = '0; m_holdw = '0;
  endtask

  task automatic model_step();
    m_acc = in_valid && !m_hold;
    if (m_busy) begin
      if (m_k == 2 * div_m * W - 1) begin
        if (m_hold) begin
          m_cur = m_holdw; m_hold = 0; m_k = 0;
        end else begin
          m_busy = 0; m_k = 0;
        end
      end else begin
        m_k++;
      end
    end else if (m_hold) begin
      m_busy = 1; m_k = 0;
      m_cur = m_holdw; m_hold = 0;
    end
    if (m_acc) begin
      m_hold = 1; m_holdw = in_data;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    div_m = 1;
    checks++;
    if (obs !== expv()) begin
      failures++;
      $display("FAIL reset_d1 got=%h want=%h", obs, expv());
    end
    checks++;
    if ({r3, bz3, b3, o3, ws3, c3} !== 10'h200) begin
      failures++;
      $display("FAIL reset_d3 got=%h want=%h",
               {r3, bz3, b3, o3, ws3, c3}, 10'h200);
    end
  endtask

  task automatic test_single();
    sel = 0; div_m = 1;
    in_valid = 1; in_data = 32'h1;
    for (int i = 0; i < 72; i++) begin
      cyc();
      in_valid = 0;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL single c%0d got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] wq [2];
    int idx, nws, ws_a, ws_b;
    wq[0] = 32'h8000_0000; wq[1] = 32'hFFFF_FFFF;
    sel = 0; div_m = 1;
    idx = 0; nws = 0; ws_a = 0; ws_b = 0;
    for (int i = 0; i < 140; i++) begin
      in_valid = (idx < 2);
      in_data  = (idx < 2) ? wq[idx] : '0;
      cyc();
      if (m_acc) idx++;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL b2b c%0d got=%h want=%h", i, obs, expv());
      end
      if (obs[5]) begin
        nws++;
        if (nws == 1) ws_a = cyc_n;
        if (nws == 2) ws_b = cyc_n;
      end
    end
    in_valid = 0;
    checks++;
    if (nws !== 2) begin
      failures++;
      $display("FAIL b2b_ws_count got=%0d want=2", nws);
    end
    checks++;
    if (ws_b - ws_a !== 2 * W) begin
      failures++;
      $display("FAIL b2b_ws_spacing got=%0d want=%0d",
               ws_b - ws_a, 2 * W);
    end
  endtask

  task automatic test_div3();
    logic [W-1:0] asm_w;
    logic pb, po, pbz;
    logic [4:0] pc;
    sel = 1; div_m = 3;
    asm_w = '0;
    pb = 0; po = 0; pbz = 0; pc = '0;
    in_valid = 1; in_data = 32'hA5A5_A5A5;
    for (int i = 0; i < 2 * 3 * W + 8; i++) begin
      cyc();
      in_valid = 0;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL div3 c%0d got=%h want=%h", i, obs, expv());
      end
      if (!pb && obs[7]) asm_w[obs[4:0]] = obs[6];
      if (pbz && obs[8] && (obs[6] !== po || obs[4:0] !== pc)) begin
        checks++;
        if (!(pb && !obs[7])) begin
          failures++;
          $display("FAIL div3_change c%0d bclk=%b->%b want=1->0",
                   i, pb, obs[7]);
        end
      end
      pb = obs[7]; po = obs[6]; pc = obs[4:0]; pbz = obs[8];
    end
    checks++;
    if (asm_w !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL div3_word got=%h want=%h", asm_w, 32'hA5A5_A5A5);
    end
    sel = 0; div_m = 1;
  endtask

  task automatic test_stream();
    logic [W-1:0] sent [$];
    logic [W-1:0] rx [$];
    logic [W-1:0] asm_w;
    logic pb;
    int idx;
    sel = 0; div_m = 1;
    for (int i = 0; i < 4; i++) sent.push_back($urandom);
    idx = 0; pb = 0; asm_w = '0;
    in_valid = 1; in_data = sent[0];
    for (int i = 0; i < 4 * 2 * W + 20; i++) begin
      cyc();
      if (m_acc) begin
        idx++;
        in_data = (idx < 4) ? sent[idx] : $urandom;
        in_valid = (idx < 4);
      end
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL stream c%0d got=%h want=%h", i, obs, expv());
      end
      if (!pb && obs[7]) begin
        asm_w[obs[4:0]] = obs[6];
        if (obs[4:0] == 5'(W - 1)) rx.push_back(asm_w);
      end
      pb = obs[7];
    end
    in_valid = 0;
    checks++;
    if (rx.size() !== 4) begin
      failures++;
      $display("FAIL stream_count got=%0d want=4", rx.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) begin
        checks++;
        if (rx[i] !== sent[i]) begin
          failures++;
          $display("FAIL stream_w%0d got=%h want=%h", i, rx[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_gap();
    int t, rise_at;
    logic done;
    sel = 0; div_m = 1;
    in_valid = 1; in_data = $urandom;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      in_valid = 0;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL gap_a c%0d got=%h want=%h", i, obs, expv());
      end
      if (i > 0 && !m_busy) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL gap_end timeout got=busy want=idle");
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL gap_idle c%0d got=%h want=%h", i, obs, expv());
      end
    end
    in_valid = 1; in_data = $urandom;
    cyc();
    t = cyc_n;
    in_valid = 0;
    rise_at = -1;
    for (int i = 0; i < 70; i++) begin
      cyc();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL gap_b c%0d got=%h want=%h", i, obs, expv());
      end
      if (rise_at < 0 && obs[7]) rise_at = cyc_n;
    end
    checks++;
    if (rise_at !== t + 2) begin
      failures++;
      $display("FAIL gap_latency got=%0d want=%0d", rise_at - t, 2);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    sel = 0; div_m = 1;
    in_valid = 1; in_data = $urandom | 32'h0000_2000;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      in_valid = 0;
      if (obs[4:0] == 5'd13) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_mid_wait got=timeout want=counter13");
    end
    rst_n = 0;
    #1;
    checks++;
    if (obs !== 10'h200) begin
      failures++;
      $display("FAIL rst_mid_async got=%h want=%h", obs, 10'h200);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; in_data = 32'h1234_5678;
    for (int i = 0; i < 72; i++) begin
      cyc();
      in_valid = 0;
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL rst_mid_word c%0d got=%h want=%h", i, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    int nw, idx, gap;
    logic done;
    for (int n = 0; n < 6; n++) begin
      sel = $urandom_range(0, 1);
      div_m = (sel == 1) ? 3 : 1;
      gap = $urandom_range(0, 6);
      nw = $urandom_range(1, 2);
      for (int i = 0; i < gap; i++) begin
        cyc();
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL rand_gap n%0d got=%h want=%h", n, obs, expv());
        end
      end
      idx = 0; done = 0;
      in_data = $urandom;
      for (int i = 0; i < 2 * 3 * W * 2 + 20; i++) begin
        in_valid = (idx < nw);
        cyc();
        if (m_acc) begin
          idx++;
          in_data = $urandom;
        end
        checks++;
        if (obs !== expv()) begin
          failures++;
          $display("FAIL rand n%0d c%0d got=%h want=%h",
                   n, i, obs, expv());
        end
        if (idx == nw && !m_busy && !m_hold) begin
          done = 1;
          break;
        end
      end
      in_valid = 0;
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL rand_done n%0d got=timeout want=idle", n);
      end
    end
    sel = 0; div_m = 1;
  endtask

  initial begin
    model_reset();
    div_m = 1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    test_single();
    test_back_to_back();
    test_div3();
    test_stream();
    test_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
